// File: rtl/jogador_automatico.sv
// Automated player: records the game's LED flashes, replays them on the buttons.
// Ports: clock, reset (async, high), habilita, leds[7:0], aguarda_jogada,
//   acertou/errou/timeout (game end) -> botoes[7:0], num_jogadas[4:0],
//   erro_protocolo (sticky), fim, db_estado[3:0].
module jogador_automatico #(
  parameter int MAX_JOGADAS = 16,
  parameter int T_PRESSIONA = 8,
  parameter int T_SOLTA     = 8,
  parameter int T_ATRASO    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [7:0] leds,
  input  logic       aguarda_jogada,
  input  logic       acertou,
  input  logic       errou,
  input  logic       timeout,
  output logic [7:0] botoes,
  output logic [4:0] num_jogadas,
  output logic       erro_protocolo,
  output logic       fim,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    OBSERVA   = 4'd1,
    ATRASO    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    PROXIMA   = 4'd5,
    FIM       = 4'd6
  } estado_t;

  localparam int TM1  = (T_PRESSIONA > T_SOLTA) ? T_PRESSIONA : T_SOLTA;
  localparam int TMAX = (TM1 > T_ATRASO) ? TM1 : T_ATRASO;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int IW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;

  estado_t       estado_q, estado_d;
  logic [7:0]    leds_q, leds_ant_q;
  logic          agu_q, agu_ant_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4:0]    num_q, num_d;
  logic [7:0]    botoes_q, botoes_d;
  logic          erro_q, erro_d;
  logic          fim_q, fim_d;

  logic [2:0]    mem_q [MAX_JOGADAS];
  logic          mem_we;
  logic [2:0]    led_idx;
  logic          led_sobe, one_hot, agu_sobe, fim_jogo;
  logic [IW-1:0] idx_prox;
  logic          ultimo;

  assign led_sobe = (leds_q != 8'd0) && (leds_ant_q == 8'd0);
  assign one_hot  = (leds_q & (leds_q - 8'd1)) == 8'd0;
  assign agu_sobe = agu_q && !agu_ant_q;
  assign fim_jogo = acertou | errou | timeout;
  assign idx_prox = idx_q + IW'(1);
  assign ultimo   = 5'(idx_q) == (num_q - 5'd1);

  always_comb begin
    led_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (leds_q[i]) led_idx = 3'(i);
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    num_d    = num_q;
    botoes_d = botoes_q;
    erro_d   = erro_q;
    fim_d    = fim_q;
    mem_we   = 1'b0;
    if (!habilita) begin
      estado_d = INICIAL;
      botoes_d = 8'd0;
      num_d    = 5'd0;
      fim_d    = 1'b0;
    end else if (estado_q != INICIAL && fim_jogo) begin
      estado_d = FIM;
      botoes_d = 8'd0;
      fim_d    = 1'b1;
    end else begin
      unique case (estado_q)
        INICIAL: begin
          botoes_d = 8'd0;
          num_d    = 5'd0;
          fim_d    = 1'b0;
          estado_d = OBSERVA;
        end
        OBSERVA: begin
          if (agu_sobe) begin
            if (num_q != 5'd0) begin
              estado_d = ATRASO;
              cnt_d    = CW'(T_ATRASO - 1);
              idx_d    = '0;
            end else begin
              estado_d = FIM;
              fim_d    = 1'b1;
              erro_d   = 1'b1;
            end
          end else if (led_sobe) begin
            if (!one_hot || num_q == 5'(MAX_JOGADAS)) begin
              erro_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              num_d  = num_q + 5'd1;
            end
          end
        end
        ATRASO: begin
          if (cnt_q == '0) begin
            estado_d = PRESSIONA;
            cnt_d    = CW'(T_PRESSIONA - 1);
            botoes_d = 8'd1 << mem_q[idx_q];
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        PRESSIONA: begin
          if (cnt_q == '0) begin
            estado_d = SOLTA;
            cnt_d    = CW'(T_SOLTA - 1);
            botoes_d = 8'd0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SOLTA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (ultimo) begin
            estado_d = PROXIMA;
          end else begin
            estado_d = PRESSIONA;
            idx_d    = idx_prox;
            cnt_d    = CW'(T_PRESSIONA - 1);
            botoes_d = 8'd1 << mem_q[idx_prox];
          end
        end
        PROXIMA: begin
          num_d    = 5'd0;
          estado_d = OBSERVA;
        end
        FIM: begin
          botoes_d = 8'd0;
          fim_d    = 1'b1;
        end
        default: estado_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      leds_q     <= 8'd0;
      leds_ant_q <= 8'd0;
      agu_q      <= 1'b0;
      agu_ant_q  <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      num_q      <= 5'd0;
      botoes_q   <= 8'd0;
      erro_q     <= 1'b0;
      fim_q      <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      leds_q     <= leds;
      leds_ant_q <= leds_q;
      agu_q      <= aguarda_jogada;
      agu_ant_q  <= agu_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      botoes_q   <= botoes_d;
      erro_q     <= erro_d;
      fim_q      <= fim_d;
    end
  end

  // Memory is never reset; entries past num_q are simply stale.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[num_q[IW-1:0]] <= led_idx;
  end

  assign botoes         = botoes_q;
  assign num_jogadas    = num_q;
  assign erro_protocolo = erro_q;
  assign fim            = fim_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: directed vector table plus replay sequences
// checked against a queue of expected button presses.
module tb_jogador_automatico;

  localparam int TP = 8;
  localparam int TS = 8;
  localparam int TA = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [7:0] leds = 8'd0;
  logic       agu = 1'b0;
  logic       acertou = 1'b0;
  logic       errou = 1'b0;
  logic       timeout = 1'b0;
  logic [7:0] botoes;
  logic [4:0] num_jogadas;
  logic       erro_protocolo;
  logic       fim;
  logic [3:0] db_estado;

  jogador_automatico dut (
    .clock          (clk),
    .reset          (reset),
    .habilita       (habilita),
    .leds           (leds),
    .aguarda_jogada (agu),
    .acertou        (acertou),
    .errou          (errou),
    .timeout        (timeout),
    .botoes         (botoes),
    .num_jogadas    (num_jogadas),
    .erro_protocolo (erro_protocolo),
    .fim            (fim),
    .db_estado      (db_estado)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  int  model_n;
  int  n_press = 0;
  bit  chk_width = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press monitor: pops the expected press on each rising edge of botoes.
  logic [7:0] prev_b = 8'd0;
  int  hi_cnt = 0;
  int  gap_cnt = 0;
  bit  gap_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_b    = 8'd0;
      hi_cnt    = 0;
      gap_valid = 1'b0;
    end else begin
      if (botoes != 8'd0 && prev_b == 8'd0) begin
        if (gap_valid && gap_cnt < 16) check("gap", gap_cnt, TS);
        if (exp_q.size() == 0) begin
          check("press_extra", int'(botoes), 0);
        end else begin
          check("press", int'(botoes), int'(exp_q.pop_front()));
        end
        n_press++;
        hi_cnt = 1;
      end else if (botoes != 8'd0) begin
        if (botoes != prev_b) check("press_stable", int'(botoes), int'(prev_b));
        hi_cnt++;
      end else if (prev_b != 8'd0) begin
        if (chk_width) check("width", hi_cnt, TP);
        gap_valid = 1'b1;
        gap_cnt   = 1;
      end else begin
        gap_cnt++;
      end
      prev_b = botoes;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    habilita = 1'b0; leds = 8'd0; agu = 1'b0;
    acertou = 1'b0; errou = 1'b0; timeout = 1'b0;
    exp_q.delete();
    model_n = 0;
    repeat (2) tick();
    reset = 1'b0;
    chk_width = 1'b1;
    tick();
  endtask

  // One LED flash: 5 cycles lit, 3 dark; the model records what it expects replayed.
  task automatic flash(input logic [7:0] v);
    if ((v & (v - 8'd1)) == 8'd0 && v != 8'd0 && model_n < 16) begin
      exp_q.push_back(v);
      model_n++;
    end
    leds = v;
    repeat (5) tick();
    leds = 8'd0;
    repeat (3) tick();
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      if (db_estado == s) break;
      tick();
    end
    if (i == lim) check({nm, "_timeout"}, int'(db_estado), int'(s));
  endtask

  task automatic wait_press(input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      if (botoes != 8'd0) break;
      tick();
    end
    if (i == lim) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic start_round();
    habilita = 1'b1;
    repeat (2) tick();
  endtask

  typedef struct {
    logic       rst;
    logic       hab;
    logic [7:0] leds;
    logic       agu;
    logic [2:0] fimj;
    logic [3:0] st;
    logic [4:0] num;
    logic       erro;
    logic       fim;
    logic [7:0] bot;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int p0, a;
    // rst hab leds agu {acertou,errou,timeout} | st num erro fim bot
    tbl[0]  = '{0, 1, 8'h00, 0, 3'b000, 4'd1, 5'd0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 8'h00, 1, 3'b000, 4'd1, 5'd0, 0, 0, 8'h00};
    tbl[2]  = '{0, 1, 8'h00, 1, 3'b000, 4'd6, 5'd0, 1, 1, 8'h00};
    tbl[3]  = '{0, 1, 8'h00, 0, 3'b000, 4'd6, 5'd0, 1, 1, 8'h00};
    tbl[4]  = '{0, 0, 8'h00, 0, 3'b000, 4'd0, 5'd0, 1, 0, 8'h00};
    tbl[5]  = '{1, 0, 8'h00, 0, 3'b000, 4'd0, 5'd0, 0, 0, 8'h00};
    tbl[6]  = '{0, 1, 8'h00, 0, 3'b000, 4'd1, 5'd0, 0, 0, 8'h00};
    tbl[7]  = '{0, 1, 8'h06, 0, 3'b000, 4'd1, 5'd0, 0, 0, 8'h00};
    tbl[8]  = '{0, 1, 8'h06, 0, 3'b000, 4'd1, 5'd0, 1, 0, 8'h00};
    tbl[9]  = '{0, 1, 8'h00, 0, 3'b000, 4'd1, 5'd0, 1, 0, 8'h00};
    tbl[10] = '{0, 1, 8'h10, 0, 3'b000, 4'd1, 5'd0, 1, 0, 8'h00};
    tbl[11] = '{0, 1, 8'h10, 0, 3'b000, 4'd1, 5'd1, 1, 0, 8'h00};
    tbl[12] = '{0, 1, 8'h00, 0, 3'b000, 4'd1, 5'd1, 1, 0, 8'h00};
    tbl[13] = '{0, 1, 8'h00, 0, 3'b010, 4'd6, 5'd1, 1, 1, 8'h00};
    tbl[14] = '{0, 0, 8'h00, 0, 3'b000, 4'd0, 5'd0, 1, 0, 8'h00};
    tbl[15] = '{0, 0, 8'h00, 0, 3'b010, 4'd0, 5'd0, 1, 0, 8'h00};
    tbl[16] = '{0, 1, 8'h00, 0, 3'b001, 4'd1, 5'd0, 1, 0, 8'h00};
    tbl[17] = '{0, 1, 8'h00, 0, 3'b001, 4'd6, 5'd0, 1, 1, 8'h00};
    tbl[18] = '{0, 0, 8'h00, 0, 3'b000, 4'd0, 5'd0, 1, 0, 8'h00};

    do_reset();
    check("rst_botoes", int'(botoes), 0);
    check("rst_num", int'(num_jogadas), 0);
    check("rst_erro", int'(erro_protocolo), 0);
    check("rst_fim", int'(fim), 0);
    check("rst_estado", int'(db_estado), 0);

    for (int i = 0; i < 19; i++) begin
      reset    = tbl[i].rst;
      habilita = tbl[i].hab;
      leds     = tbl[i].leds;
      agu      = tbl[i].agu;
      {acertou, errou, timeout} = tbl[i].fimj;
      tick();
      check($sformatf("vec%0d_estado", i), int'(db_estado), int'(tbl[i].st));
      check($sformatf("vec%0d_num", i), int'(num_jogadas), int'(tbl[i].num));
      check($sformatf("vec%0d_erro", i), int'(erro_protocolo), int'(tbl[i].erro));
      check($sformatf("vec%0d_fim", i), int'(fim), int'(tbl[i].fim));
      check($sformatf("vec%0d_botoes", i), int'(botoes), int'(tbl[i].bot));
    end

    // Basic replay of three colours.
    do_reset();
    start_round();
    flash(8'h04);
    flash(8'h01);
    flash(8'h80);
    check("basic_num", int'(num_jogadas), 3);
    check("basic_erro", int'(erro_protocolo), 0);
    p0 = n_press;
    agu = 1'b1;
    a = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (db_estado == 4'd2) a++;
      if (db_estado == 4'd3) break;
    end
    check("basic_atraso", a, TA);
    wait_state(4'd5, 300, "basic_proxima");
    tick();
    check("basic_obs_estado", int'(db_estado), 1);
    check("basic_obs_num", int'(num_jogadas), 0);
    check("basic_presses", n_press - p0, 3);
    check("basic_queue", exp_q.size(), 0);
    agu = 1'b0;

    // Overflow: 17 flashes, only 16 kept.
    do_reset();
    start_round();
    for (int i = 0; i < 17; i++) begin
      logic [7:0] v;
      v = 8'd1 << (i % 8);
      flash(v);
    end
    check("ovf_num", int'(num_jogadas), 16);
    check("ovf_erro", int'(erro_protocolo), 1);
    p0 = n_press;
    agu = 1'b1;
    tick();
    wait_state(4'd5, 1000, "ovf_proxima");
    tick();
    check("ovf_presses", n_press - p0, 16);
    check("ovf_queue", exp_q.size(), 0);
    agu = 1'b0;

    // Game end mid-press.
    do_reset();
    start_round();
    flash(8'h02);
    agu = 1'b1;
    wait_press(50, "end_press");
    chk_width = 1'b0;
    check("end_pressing", int'(botoes), 8'h02);
    tick();
    tick();
    errou = 1'b1;
    tick();
    check("end_botoes", int'(botoes), 0);
    check("end_fim", int'(fim), 1);
    check("end_estado", int'(db_estado), 6);
    errou = 1'b0;
    habilita = 1'b0;
    agu = 1'b0;
    tick();
    check("end_inicial", int'(db_estado), 0);

    // Asynchronous reset mid-press, away from any clock edge.
    do_reset();
    start_round();
    flash(8'h08);
    check("arst_num_pre", int'(num_jogadas), 1);
    agu = 1'b1;
    wait_press(50, "arst_press");
    chk_width = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_botoes", int'(botoes), 0);
    check("arst_num", int'(num_jogadas), 0);
    check("arst_estado", int'(db_estado), 0);
    #10;
    reset = 1'b0;
    agu = 1'b0;
    habilita = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automated player that sits on the opposite side of the game's LED/button interface.
- Watches the game's `leds` output and records each displayed colour.
- When the game signals it is awaiting a play, replays the recorded sequence on the game's `botoes` input with controlled press and release timing.
- Used on the bench and on the board to run unattended games and collect timing data through the Analog Discovery.

Parameters:
- MAX_JOGADAS, 16: depth of the sequence memory (entries).
- T_PRESSIONA, 8: clock cycles each button is held high.
- T_SOLTA, 8: clock cycles all buttons are held low between presses.
- T_ATRASO, 4: clock cycles after `aguarda_jogada` rises before the first press.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- habilita  in  1  enables the player; low forces INICIAL.
- leds  in  8  LED outputs of the game, expected one-hot or zero.
- aguarda_jogada  in  1  high while the game waits for a button press.
- acertou  in  1  game end: win.
- errou  in  1  game end: wrong play.
- timeout  in  1  game end: timeout.
- botoes  out  8  one-hot button press driven into the game.
- num_jogadas  out  5  number of entries currently recorded.
- erro_protocolo  out  1  sticky flag: illegal LED pattern or memory overflow.
- fim  out  1  high in FIM.
- db_estado  out  4  state code.

Behaviour:
- Reset is asynchronous, active-high, single clock domain.
- Reset values: `botoes`=0, `num_jogadas`=0, `erro_protocolo`=0, `fim`=0, state INICIAL (`db_estado`=0). The memory is not cleared; it is invalidated by the count.
- `leds` and `aguarda_jogada` are registered once before use. All edge detection uses the registered copies, so there is 1 cycle of input latency.
- Encoding: an entry is the 3-bit index of the set bit of `leds`. Capture occurs on the cycle where registered `leds` goes from 0 to nonzero.
  - Nonzero value that is not one-hot: set `erro_protocolo`, do not store.
  - Capture with `num_jogadas`=MAX_JOGADAS: set `erro_protocolo`, drop the entry, leave the count unchanged.
- States (`db_estado` code):
  - INICIAL (0): `botoes`=0, count cleared. If `habilita` is high -> OBSERVA.
  - OBSERVA (1): capture LED flashes as above.
    - Rise of `aguarda_jogada` with count > 0 -> ATRASO.
    - Rise with count = 0 -> FIM; set `erro_protocolo`.
  - ATRASO (2): wait T_ATRASO cycles -> PRESSIONA. The replay index is reset to 0.
  - PRESSIONA (3): `botoes` = one-hot of mem[index], registered output. Hold T_PRESSIONA cycles -> SOLTA.
  - SOLTA (4): `botoes`=0, hold T_SOLTA cycles.
    - If index = count-1 -> PROXIMA.
    - Otherwise increment index and go back to PRESSIONA. The next press waits; it does not require `aguarda_jogada` to re-rise.
  - PROXIMA (5): clear count -> OBSERVA, ready for the next round. The game re-displays the full sequence each round.
  - FIM (6): `botoes`=0, `fim`=1. Stays until `habilita` is low, then -> INICIAL.
- Priority 1: if `acertou`, `errou` or `timeout` is high in any state other than INICIAL, go to FIM next cycle. `botoes` goes to 0 on the same edge.
- Priority 2: if `habilita` is low in any state, go to INICIAL next cycle. This takes precedence over the game-end inputs.
- `botoes` is never multi-hot and never changes except at state boundaries.
- Reset mid-press drops `botoes` to 0 immediately (asynchronous).
- LED captures are ignored outside OBSERVA. Game LED feedback during replay is not recorded.
- The timing counters are wide enough for the max of T_PRESSIONA, T_SOLTA and T_ATRASO, and wrap only via reload at each state entry.

Test Plan:
- Basic replay:
  - Stimulus: `habilita`=1; `leds` pulses 0x04, 0x01, 0x80 (each 5 cycles, 3-cycle gaps); then `aguarda_jogada`=1.
  - Response: `num_jogadas`=3. `botoes` shows 0x04, 0x01, 0x80, each 8 cycles high with 8-cycle low gaps. The first press starts 4 cycles after registered `aguarda_jogada` rises. Then the block is in OBSERVA with `num_jogadas`=0.
- Illegal pattern:
  - Stimulus: `leds`=0x06 in OBSERVA.
  - Response: `erro_protocolo`=1 (sticky), `num_jogadas` unchanged.
- Overflow:
  - Stimulus: 17 one-hot flashes.
  - Response: `num_jogadas`=16, `erro_protocolo`=1, replay produces 16 presses.
- Game end mid-press:
  - Stimulus: `errou`=1 during PRESSIONA.
  - Response: next cycle `botoes`=0, `fim`=1, `db_estado`=6. Dropping `habilita` -> `db_estado`=0.
- Empty wait:
  - Stimulus: `aguarda_jogada` rises with count 0.
  - Response: FIM, `erro_protocolo`=1, no press issued.
- Asynchronous reset mid-replay:
  - Stimulus: `reset` pulse during PRESSIONA.
  - Response: `botoes`=0 and `num_jogadas`=0 without waiting for a clock edge; `db_estado`=0.
